quick_spi_soft: RTL and testbench

Self-contained, one-shot SPI master ("soft" sequencer) that runs one fixed transaction after reset release. The transaction is a 16-bit write of a parameterised header followed by an 8-bit read.
- Clock and reset ports are named in AXI style for drop-in placement beside AXI peripherals; there is no AXI bus interface.
- Used as a bring-up or demo SPI driver toward up to two slaves.

---
 rtl/quick_spi_soft_pkg.sv | 20 ++
 rtl/quick_spi_sclk_gen.sv | 43 ++++
 rtl/quick_spi_soft.sv | 161 ++++++++++++++++
 tb/tb_quick_spi_soft.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/quick_spi_soft_pkg.sv
// Shared types and constants for the quick_spi_soft one-shot SPI master.
package quick_spi_soft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT_SS,
    WRITE,
    READ,
    DEASSERT,
    DONE
  } state_t;

  localparam logic [1:0] SS_IDLE = 2'b11;
  localparam logic       CPOL    = 1'b0;
  localparam logic       CPHA    = 1'b0;

  // Wide enough to hold a bit count of 16 (WRITE_BITS upper bound).
  localparam int BIT_CNT_W = 5;

endpackage

// File: rtl/quick_spi_sclk_gen.sv
// SPI clock generator: divides clk by HALF_PERIOD, emits sclk plus tick/rise/fall strobes.
module quick_spi_sclk_gen
  import quick_spi_soft_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_toggle,
  output logic o_tick,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;

  // A tick marks the clock edge that closes the current half-period interval.
  assign o_tick = i_run && (r_cnt == CNT_W'(HALF_PERIOD - 1));
  assign o_sclk = r_sclk;
  assign o_rise = o_tick && i_toggle && (r_sclk == CPOL);
  assign o_fall = o_tick && i_toggle && (r_sclk != CPOL);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= CPOL;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= CPOL;
    end else begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
      if (o_tick) begin
        r_sclk <= i_toggle ? ~r_sclk : CPOL;
      end
    end
  end

endmodule

// File: rtl/quick_spi_soft.sv
// One-shot SPI master: after reset release writes OUTGOING_DATA then reads READ_BITS from miso.
// Define QUICK_SPI_SOFT_DEBUG_EN to expose incoming_data and end_of_transaction ports.
module quick_spi_soft
  import quick_spi_soft_pkg::*;
#(
  parameter logic [15:0] OUTGOING_DATA = 16'h1A6A,
  parameter int          WRITE_BITS    = 16,
  parameter int          READ_BITS     = 8,
  parameter int          SLAVE_INDEX   = 0,
  parameter int          HALF_PERIOD   = 1
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_aresetn,
  output logic       mosi,
  input  logic       miso,
  output logic       sclk,
  output logic [1:0] ss_n
`ifdef QUICK_SPI_SOFT_DEBUG_EN
  ,
  output logic [7:0] incoming_data,
  output logic       end_of_transaction
`endif
);

  localparam logic [1:0]           SS_SEL  = (SLAVE_INDEX == 1) ? 2'b01 : 2'b10;
  localparam logic [15:0]          TX_INIT = OUTGOING_DATA << (16 - WRITE_BITS);
  localparam logic [BIT_CNT_W-1:0] W_CNT   = BIT_CNT_W'(WRITE_BITS);
  localparam logic [BIT_CNT_W-1:0] R_CNT   = BIT_CNT_W'(READ_BITS);

  state_t               r_state, w_state_next;
  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
  logic [15:0]          r_tx, w_tx_next;
  logic [7:0]           r_rx, w_rx_next;
  logic [7:0]           r_incoming, w_incoming_next;
  logic [1:0]           r_ss_n, w_ss_n_next;
  logic                 r_eot, w_eot_next;

  logic w_run;
  logic w_toggle;
  logic w_tick;
  logic w_sclk;
  logic w_rise;
  logic w_fall;
  logic w_tx_edge;

  assign w_run = (r_state != IDLE) && (r_state != DONE);

  // Once the last bit of a phase has completed, sclk must stay low for the trailing half-period.
  assign w_toggle = (r_state == ASSERT_SS)
                 || ((r_state == WRITE) && ((r_bit_cnt != W_CNT) || (READ_BITS != 0)))
                 || ((r_state == READ) && (r_bit_cnt != R_CNT));

  quick_spi_sclk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sclk_gen (
    .clk     (s_axi_aclk),
    .i_rst_n (s_axi_aresetn),
    .i_run   (w_run),
    .i_toggle(w_toggle),
    .o_tick  (w_tick),
    .o_sclk  (w_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_tx_edge = (CPHA == 1'b0) ? w_fall : w_rise;

  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_tx_next       = r_tx;
    w_rx_next       = r_rx;
    w_incoming_next = r_incoming;
    w_ss_n_next     = r_ss_n;
    w_eot_next      = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = ASSERT_SS;
        w_ss_n_next  = SS_SEL;
        w_tx_next    = TX_INIT;
      end
      ASSERT_SS: begin
        if (w_tick) begin
          w_state_next   = WRITE;
          w_bit_cnt_next = '0;
        end
      end
      WRITE: begin
        if (w_tx_edge) begin
          w_tx_next      = {r_tx[14:0], 1'b0};
          w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
        end else if (w_tick && (r_bit_cnt == W_CNT)) begin
          if (READ_BITS == 0) begin
            w_state_next    = DEASSERT;
            w_ss_n_next     = SS_IDLE;
            w_incoming_next = r_rx;
            w_eot_next      = 1'b1;
          end else begin
            w_state_next   = READ;
            w_bit_cnt_next = '0;
          end
        end
      end
      READ: begin
        if (w_fall) begin
          w_rx_next      = {r_rx[6:0], miso};
          w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
        end else if (w_tick && (r_bit_cnt == R_CNT)) begin
          w_state_next    = DEASSERT;
          w_ss_n_next     = SS_IDLE;
          w_incoming_next = r_rx;
          w_eot_next      = 1'b1;
        end
      end
      DEASSERT: begin
        if (w_tick) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_incoming <= '0;
      r_ss_n     <= SS_IDLE;
      r_eot      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_tx       <= w_tx_next;
      r_rx       <= w_rx_next;
      r_incoming <= w_incoming_next;
      r_ss_n     <= w_ss_n_next;
      r_eot      <= w_eot_next;
    end
  end

  assign mosi = r_tx[15];
  assign sclk = w_sclk;
  assign ss_n = r_ss_n;

`ifdef QUICK_SPI_SOFT_DEBUG_EN
  assign incoming_data      = r_incoming;
  assign end_of_transaction = r_eot;
`else
  logic w_unused;
  assign w_unused = ^{r_incoming, r_eot};
`endif

endmodule

// File: tb/tb_quick_spi_soft.sv
// Self-checking bench: three quick_spi_soft variants run side by side against a per-cycle waveform model.
module tb_quick_spi_soft;

  localparam int NDUT = 3;
  localparam int NCYC = 170;

  // Variant 0: defaults. Variant 1: slave 1, half-period 3. Variant 2: 5-bit write, no read.
  localparam logic [2:0][15:0] D_P = {16'hFFF3, 16'h1A6A, 16'h1A6A};
  localparam logic [2:0][4:0]  W_P = {5'd5, 5'd16, 5'd16};
  localparam logic [2:0][3:0]  R_P = {4'd0, 4'd8, 4'd8};
  localparam logic [2:0][1:0]  T_P = {2'd2, 2'd3, 2'd1};
  localparam logic [2:0]       S_P = 3'b010;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       miso = 1'b0;
  logic       sclk_v [NDUT];
  logic       mosi_v [NDUT];
  logic [1:0] ss_v   [NDUT];
`ifdef QUICK_SPI_SOFT_DEBUG_EN
  logic [7:0] inc_v  [NDUT];
  logic       eot_v  [NDUT];
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic miso_hist [NCYC];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      quick_spi_soft #(
        .OUTGOING_DATA(D_P[gi]),
        .WRITE_BITS   (int'(W_P[gi])),
        .READ_BITS    (int'(R_P[gi])),
        .SLAVE_INDEX  (int'(S_P[gi])),
        .HALF_PERIOD  (int'(T_P[gi]))
      ) u_dut (
        .s_axi_aclk        (clk),
        .s_axi_aresetn     (rstn),
        .mosi              (mosi_v[gi]),
        .miso              (miso),
        .sclk              (sclk_v[gi]),
        .ss_n              (ss_v[gi])
`ifdef QUICK_SPI_SOFT_DEBUG_EN
        ,
        .incoming_data     (inc_v[gi]),
        .end_of_transaction(eot_v[gi])
`endif
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected {sclk, mosi, ss_n} for the interval following edge j after reset release
  // (j = -1: the idle cycle before the first edge, or any reset cycle).
  function automatic logic [3:0] exp_pins(input int d, input int j);
    int          t    = int'(T_P[d]);
    int          w    = int'(W_P[d]);
    int          r    = int'(R_P[d]);
    logic [15:0] data = D_P[d];
    logic [1:0]  sel  = S_P[d] ? 2'b01 : 2'b10;
    int          e    = t + 2 * t * (w + r);
    int          m;
    int          mb;
    logic        hi;
    logic        mo;
    if (j < 0 || j >= e) return 4'b0011;
    if (j < t) return {1'b0, data[w-1], sel};
    m  = j - t;
    mb = (m + t) / (2 * t);
    hi = ((m % (2 * t)) < t);
    mo = (mb < w) ? data[w-1-mb] : 1'b0;
    return {hi, mo, sel};
  endfunction

  function automatic int end_idx(input int d);
    return int'(T_P[d]) * (1 + 2 * (int'(W_P[d]) + int'(R_P[d])));
  endfunction

  // Byte assembled from miso as it stood at each read-phase falling sclk edge.
  function automatic logic [7:0] exp_rx(input int d);
    int         t = int'(T_P[d]);
    int         w = int'(W_P[d]);
    logic [7:0] v = 8'h00;
    for (int k = 0; k < int'(R_P[d]); k++) begin
      v = {v[6:0], miso_hist[t + 2 * t * (w + k) + t]};
    end
    return v;
  endfunction

  // mode 0 random, 1 all ones, 2 all zeros, 3 variant 0 samples 8'hA5.
  function automatic logic pick_miso(input int mode, input int j);
    logic [7:0] pat = 8'hA5;
    case (mode)
      1: return 1'b1;
      2: return 1'b0;
      3: if (j >= 34 && j <= 48 && (j % 2) == 0) return pat[7 - (j - 34) / 2];
      default: ;
    endcase
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_idle(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("%s_pins%0d", tag, d), 32'({sclk_v[d], mosi_v[d], ss_v[d]}), 32'(exp_pins(d, -1)));
`ifdef QUICK_SPI_SOFT_DEBUG_EN
      check_eq($sformatf("%s_eot%0d", tag, d), 32'(eot_v[d]), 32'd0);
      check_eq($sformatf("%s_inc%0d", tag, d), 32'(inc_v[d]), 32'd0);
`endif
    end
  endtask

  // Called at a negedge with reset asserted; releases reset, runs the frame, re-asserts reset.
  task automatic run_frame(input int mode, input int abort_at);
    int   rises   [NDUT];
    int   low_cnt [NDUT];
    logic prev    [NDUT];
    int   f0 = n_fail;
    int   c0 = n_checks;
    rstn = 1'b1;
    check_idle("release");
    for (int d = 0; d < NDUT; d++) begin
      rises[d]   = 0;
      low_cnt[d] = 0;
      prev[d]    = 1'b0;
    end
    for (int j = 0; j < NCYC; j++) begin
      miso         = pick_miso(mode, j);
      miso_hist[j] = miso;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        check_eq($sformatf("pins%0d_j%0d", d, j), 32'({sclk_v[d], mosi_v[d], ss_v[d]}), 32'(exp_pins(d, j)));
`ifdef QUICK_SPI_SOFT_DEBUG_EN
        check_eq($sformatf("eot%0d_j%0d", d, j), 32'(eot_v[d]), 32'(j == end_idx(d)));
        check_eq($sformatf("inc%0d_j%0d", d, j), 32'(inc_v[d]), 32'((j >= end_idx(d)) ? exp_rx(d) : 8'h00));
`endif
        if (sclk_v[d] && !prev[d]) rises[d]++;
        if (ss_v[d] != 2'b11) low_cnt[d]++;
        prev[d] = sclk_v[d];
      end
      if (j == abort_at) break;
    end
    if (abort_at < 0) begin
      for (int d = 0; d < NDUT; d++) begin
        check_eq($sformatf("rises%0d", d), 32'(rises[d]), 32'(int'(W_P[d]) + int'(R_P[d])));
        check_eq($sformatf("ss_low%0d", d), 32'(low_cnt[d]), 32'(end_idx(d)));
      end
    end
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    @(negedge clk);
    $display("frame mode=%0d abort_at=%0d checks=%0d failures=%0d", mode, abort_at,
             n_checks - c0, n_fail - f0);
  endtask

  initial begin
    rstn = 1'b0;
    miso = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("por");
    end
    run_frame(3, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(0, 11);
    run_frame(0, -1);
    run_frame(0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
